uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that produces the 8N1 line the team's `uart_rx` consumes. It is the stage directly upstream of the receiver. It accepts bytes over a valid/ready handshake into a small internal FIFO and serialises them LSB-first at `BaudRate`. Frames go back-to-back with no idle gap while the FIFO holds data. It is used as the UART output of the design and as the stimulus source for `uart_rx` loopback benches.

## Interface
- `ClkFreq`, 10_000_000, system clock frequency in Hz
- `BaudRate`, 115200, line rate in bit/s; `ClksPerBit = ClkFreq / BaudRate` (integer division, truncated; 86 at defaults)
- `FifoDepth`, 4, byte FIFO depth; power of two, ≥ 2
- One clock; reset is asynchronous and active-low. The clock port is `i_clk` and the reset port is `i_rstn`.
- `i_clk`  in  1  system clock, rising edge
- `i_rstn`  in  1  asynchronous active-low reset
- `i_tx_valid`  in  1  byte offered on `i_tx_byte`
- `i_tx_byte`  in  8  byte to send
- `o_tx_ready`  out  1  FIFO can accept; combinational `!full`
- `o_tx`  out  1  serial line, idle high, registered
- `o_tx_busy`  out  1  high whenever FSM is not IDLE
- `o_fifo_level`  out  $clog2(FifoDepth+1)  bytes currently queued

## Operation
- **Push:** a push happens on a rising edge where `i_tx_valid && o_tx_ready`. Data is stable only while valid is high; there is no hold requirement after acceptance.
- **FSM states:** IDLE, START, DATA, STOP. A baud counter counts 0..ClksPerBit-1; a 3-bit index counts data bits.
- **IDLE:**
  - `o_tx`=1.
  - If the FIFO is non-empty: pop the head into the shift register, drive `o_tx`←0, clear the counter, and go to START.
- **START:** hold 0 for ClksPerBit cycles, then `o_tx`←shift[0], index←0, go to DATA.
- **DATA:**
  - Each bit is held ClksPerBit cycles, then the register shifts right.
  - After bit 7, `o_tx`←1 and the FSM goes to STOP.
- **STOP:**
  - Hold 1 for ClksPerBit cycles.
  - At the end, if the FIFO is non-empty: pop, `o_tx`←0, go to START (back-to-back).
  - Otherwise go to IDLE.
- **Frame length:** exactly 10·ClksPerBit cycles.
- **Push and pop in the same edge:** level is unchanged and both take effect. A pop when full frees space; `o_tx_ready` rises the cycle after.
- **Writes while full:** ignored (`o_tx_ready`=0). No overflow is possible.
- **Reset:** async, at any point including mid-frame.
  - `o_tx`=1, `o_tx_busy`=0, `o_fifo_level`=0, FIFO pointers cleared (queued bytes discarded), FSM to IDLE, counters 0.
  - `o_tx_ready`=1 while and after reset.

## Timing
- **First-byte latency:** byte pushed at edge N on an empty, idle block. `o_tx` falls at edge N+1. `o_tx_busy` rises at N+1.
- **End of frame:** `o_tx_busy` falls on the edge ending the stop bit, only if no byte is queued.
- **Back-to-back:** the next start bit begins on the same edge that ends the previous stop bit.
- **Level tracking:** `o_fifo_level` is registered and updates on the push/pop edge.
- **Truncation:** ClksPerBit rounds down, so bit-time error is ≤ 1 clk/bit. At defaults that is 8.6 µs vs 8.68 µs ideal, within `uart_rx` tolerance.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding (IDLE/START/DATA/STOP), reused by `uart_rx`.
  - Constants `UART_DATA_BITS`=8 and `UART_STOP_BITS`=1.
  - A function computing clocks-per-bit from ClkFreq/BaudRate.
- **Sub-module `sync_fifo`:**
  - Parameters WIDTH, DEPTH; async active-low reset.
  - Ports: push, pop, din, dout (first-word-fall-through), full, empty, level.
  - Reusable for a later rx-side buffer.
- **Top:** FSM, baud counter, shift register.

## Test plan
- **Single byte, default params:** push 0x55.
  - `o_tx` low 86 cycles starting edge N+1, then 1,0,1,0,1,0,1,0 at 86 cycles each, then high 86 cycles.
  - `o_tx_busy` high exactly 860 cycles.
- **Loopback into `uart_rx` (same params):** push 35, 85, 60, 1, 127, 255, 2, 9 as fast as ready allows.
  - `o_rx_valid` pulses 8 times with bytes in that order.
  - No idle cycles on `o_tx` between frames.
- **Backpressure (FifoDepth=4):** hold `i_tx_valid` for 10 consecutive cycles, with distinct bytes taken from an incrementing counter so that accepted and rejected values can be told apart.
  - Exactly 5 bytes accepted (first popped at N+1); `o_tx_ready` low from the 6th cycle.
  - `o_fifo_level`=4.
  - `o_tx_ready` returns high one cycle after the first frame's stop bit ends (pop); the 6th byte is accepted then.
- **Reset mid-frame:** queue 3 bytes, drop `i_rstn` during data bit 3 of frame 1.
  - `o_tx`=1 immediately, level 0, busy 0.
  - After release, the line stays high with no further frames.
- **Non-default rate:** ClkFreq=12_000_000, BaudRate=1_000_000, push 0x00.
  - `o_tx` low 108 cycles (start + 8 data), then high 12 cycles.
  - Busy falls at cycle 120.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM encoding and baud helper
package uart_pkg;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   // Truncating division: the bit time is at most one clock short of ideal.
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // Guarded here so callers may present push/pop without checking flags.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 serial transmitter, LSB first, frames back-to-back
module uart_tx
   import uart_pkg::*;
#(
   parameter int ClkFreq   = 10_000_000,
   parameter int BaudRate  = 115200,
   parameter int FifoDepth = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rstn,
   input  logic                           i_tx_valid,
   input  logic [7:0]                     i_tx_byte,
   output logic                           o_tx_ready,
   output logic                           o_tx,
   output logic                           o_tx_busy,
   output logic [$clog2(FifoDepth+1)-1:0] o_fifo_level
);

   localparam int ClksPerBit = clks_per_bit(ClkFreq, BaudRate);
   localparam int CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

   uart_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            bit_done;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [7:0]      fifo_dout;

   assign fifo_push  = i_tx_valid && !fifo_full;
   assign o_tx_ready = !fifo_full;
   assign o_tx       = tx_q;
   assign o_tx_busy  = (state_q != UART_IDLE);
   assign bit_done   = (cnt_q == CntW'(ClksPerBit - 1));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FifoDepth)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rstn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (i_tx_byte),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_fifo_level)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= UART_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;

      unique case (state_q)
         UART_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               tx_d     = 1'b0;
               cnt_d    = '0;
               state_d  = UART_START;
            end
         end

         UART_START: begin
            if (bit_done) begin
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = UART_DATA;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         UART_DATA: begin
            if (bit_done) begin
               cnt_d = '0;
               if (idx_q == 3'(UART_DATA_BITS - 1)) begin
                  tx_d    = 1'b1;
                  state_d = UART_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         UART_STOP: begin
            if (bit_done) begin
               cnt_d = '0;
               // Chain straight into the next start bit so queued frames have no idle gap.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  tx_d     = 1'b0;
                  state_d  = UART_START;
               end else begin
                  state_d = UART_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: begin
            state_d = UART_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

   localparam int CPB     = 86;
   localparam int FRAME   = 10 * CPB;
   localparam int CPB_F   = 12;
   localparam int FRAME_F = 10 * CPB_F;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tx_valid;
   logic [7:0] tx_byte;
   logic       tx_ready;
   logic       tx_line;
   logic       tx_busy;
   logic [2:0] fifo_level;
   logic       f_valid;
   logic [7:0] f_byte;
   logic       f_ready;
   logic       f_line;
   logic       f_busy;
   logic [2:0] f_level;

   int         checks = 0;
   int         errors = 0;
   logic       line_q[$];
   logic [7:0] dec_q[$];
   int         start_q[$];
   logic [7:0] b2b_pat [8];

   always #5 clk = ~clk;

   uart_tx u_dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_tx_valid   (tx_valid),
      .i_tx_byte    (tx_byte),
      .o_tx_ready   (tx_ready),
      .o_tx         (tx_line),
      .o_tx_busy    (tx_busy),
      .o_fifo_level (fifo_level)
   );

   uart_tx #(
      .ClkFreq   (12_000_000),
      .BaudRate  (1_000_000),
      .FifoDepth (4)
   ) u_fast (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_tx_valid   (f_valid),
      .i_tx_byte    (f_byte),
      .o_tx_ready   (f_ready),
      .o_tx         (f_line),
      .o_tx_busy    (f_busy),
      .o_fifo_level (f_level)
   );

   // Expected line level i cycles after the push edge of one isolated frame.
   function automatic logic exp_line(input int i, input logic [7:0] b, input int cpb);
      if (i < 1) return 1'b1;
      if (i <= cpb) return 1'b0;
      if (i <= 9 * cpb) return b[(i - cpb - 1) / cpb];
      return 1'b1;
   endfunction

   task automatic decode_line(input int cpb);
      int i;
      logic [7:0] b;
      dec_q.delete();
      start_q.delete();
      i = 1;
      while (i + 10 * cpb <= line_q.size()) begin
         if (line_q[i-1] === 1'b1 && line_q[i] === 1'b0) begin
            for (int k = 0; k < 8; k++) b[k] = line_q[i + cpb * (k + 1) + cpb / 2];
            dec_q.push_back(b);
            start_q.push_back(i);
            i = i + 9 * cpb + cpb / 2;
         end else begin
            i++;
         end
      end
   endtask

   task automatic test_reset;
      rstn = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00; f_valid = 1'b0; f_byte = 8'h00;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_line); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (tx_line !== 1'b1 || tx_ready !== 1'b1 || f_ready !== 1'b1 || f_line !== 1'b1) begin
         errors++; $display("FAIL post_reset_idle: tx=%b ready=%b f_ready=%b f_tx=%b want 1 1 1 1", tx_line, tx_ready, f_ready, f_line);
      end
   endtask

   task automatic test_single_byte;
      int wave_err, busy_err, busy_cnt, first_bad;
      wave_err = 0; busy_err = 0; busy_cnt = 0; first_bad = -1;
      tx_valid = 1'b1; tx_byte = 8'h55;
      for (int i = 0; i < FRAME + 20; i++) begin
         @(negedge clk);
         if (i == 0) begin
            tx_valid = 1'b0;
            checks++; if (fifo_level !== 3'd1 || tx_busy !== 1'b0) begin
               errors++; $display("FAIL push_edge: level=%0d busy=%b want 1 0", fifo_level, tx_busy);
            end
         end
         if (i == 1) begin
            checks++; if (tx_line !== 1'b0 || tx_busy !== 1'b1 || fifo_level !== 3'd0) begin
               errors++; $display("FAIL first_latency: tx=%b busy=%b level=%0d want 0 1 0", tx_line, tx_busy, fifo_level);
            end
         end
         if (tx_line !== exp_line(i, 8'h55, CPB)) begin
            wave_err++;
            if (first_bad < 0) first_bad = i;
         end
         if (tx_busy === 1'b1) busy_cnt++;
         if (tx_busy !== ((i >= 1 && i <= FRAME) ? 1'b1 : 1'b0)) busy_err++;
      end
      checks++; if (wave_err != 0) begin errors++; $display("FAIL single_wave: %0d bad cycles, first at %0d, want 0", wave_err, first_bad); end
      checks++; if (busy_cnt != FRAME) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, FRAME); end
      checks++; if (busy_err != 0) begin errors++; $display("FAIL single_busy_window: %0d bad cycles want 0", busy_err); end
   endtask

   task automatic test_back_to_back;
      int k, gap_err;
      logic rdy;
      b2b_pat = '{8'd35, 8'd85, 8'd60, 8'd1, 8'd127, 8'd255, 8'd2, 8'd9};
      k = 0; gap_err = 0;
      line_q.delete();
      fork
         begin
            for (int t = 0; t < 8 * FRAME && k < 8; t++) begin
               tx_valid = 1'b1; tx_byte = b2b_pat[k]; rdy = tx_ready;
               @(negedge clk);
               if (rdy) k++;
            end
            tx_valid = 1'b0;
         end
         begin
            for (int t = 0; t < 8 * FRAME + 100; t++) begin
               @(negedge clk);
               line_q.push_back(tx_line);
            end
         end
      join
      checks++; if (k != 8) begin errors++; $display("FAIL b2b_accepted: got %0d want 8", k); end
      decode_line(CPB);
      checks++; if (dec_q.size() != 8) begin errors++; $display("FAIL b2b_frames: got %0d want 8", dec_q.size()); end
      for (int f = 0; f < 8 && f < dec_q.size(); f++) begin
         checks++; if (dec_q[f] !== b2b_pat[f]) begin errors++; $display("FAIL b2b_byte%0d: got %0d want %0d", f, dec_q[f], b2b_pat[f]); end
      end
      for (int f = 1; f < start_q.size(); f++) if (start_q[f] - start_q[f-1] != FRAME) gap_err++;
      checks++; if (gap_err != 0) begin errors++; $display("FAIL b2b_gap: %0d frames not spaced %0d cycles", gap_err, FRAME); end
      checks++; if (tx_busy !== 1'b0 || fifo_level !== 3'd0) begin
         errors++; $display("FAIL b2b_end: busy=%b level=%0d want 0 0", tx_busy, fifo_level);
      end
   endtask

   task automatic test_backpressure;
      int acc, first_rdy;
      logic sixth, rdy;
      logic [7:0] want [6];
      want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20};
      acc = 0; first_rdy = -1; sixth = 1'b0;
      line_q.delete();
      for (int i = 0; i < 6 * FRAME + 40; i++) begin
         rdy = tx_ready;
         if (i < 10) begin
            tx_valid = 1'b1; tx_byte = 8'h10 + 8'(i);
         end else if (!sixth && rdy) begin
            tx_valid = 1'b1; tx_byte = 8'h20; first_rdy = i;
         end else begin
            tx_valid = 1'b0;
         end
         if (i == 5) begin
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_6th: got %b want 0", rdy); end
         end
         @(negedge clk);
         line_q.push_back(tx_line);
         if (tx_valid && rdy) begin
            if (i < 10) acc++;
            else sixth = 1'b1;
         end
         if (i == 9) begin
            checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_full: got %0d want 4", fifo_level); end
         end
         if (i >= 10 && i == first_rdy) begin
            checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_refill: got %0d want 4", fifo_level); end
         end
      end
      tx_valid = 1'b0;
      checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted: got %0d want 5", acc); end
      checks++; if (first_rdy != FRAME + 2) begin errors++; $display("FAIL bp_ready_return: got cycle %0d want %0d", first_rdy, FRAME + 2); end
      decode_line(CPB);
      checks++; if (dec_q.size() != 6) begin errors++; $display("FAIL bp_frames: got %0d want 6", dec_q.size()); end
      for (int f = 0; f < 6 && f < dec_q.size(); f++) begin
         checks++; if (dec_q[f] !== want[f]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", f, dec_q[f], want[f]); end
      end
   endtask

   task automatic test_reset_mid_frame;
      int bad;
      logic [7:0] bytes [3];
      bytes = '{8'hA0, 8'h3C, 8'h5A};
      bad = 0;
      for (int i = 0; i <= 380; i++) begin
         if (i < 3) begin tx_valid = 1'b1; tx_byte = bytes[i]; end
         else tx_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (tx_line !== 1'b0 || fifo_level !== 3'd2) begin
         errors++; $display("FAIL mid_pre_reset: tx=%b level=%0d want 0 2", tx_line, fifo_level);
      end
      rstn = 1'b0;
      #1;
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b want 1", tx_line); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_reset_level: got %0d want 0", fifo_level); end
      checks++; if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_busy_ready: busy=%b ready=%b want 0 1", tx_busy, tx_ready);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx_line !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_after_release: %0d active cycles want 0", bad); end
   endtask

   task automatic test_fast_rate;
      int wave_err, busy_cnt, first_bad;
      wave_err = 0; busy_cnt = 0; first_bad = -1;
      f_valid = 1'b1; f_byte = 8'h00;
      for (int i = 0; i < FRAME_F + 20; i++) begin
         @(negedge clk);
         if (i == 0) f_valid = 1'b0;
         if (f_line !== exp_line(i, 8'h00, CPB_F)) begin
            wave_err++;
            if (first_bad < 0) first_bad = i;
         end
         if (f_busy === 1'b1) busy_cnt++;
         if (i == FRAME_F) begin
            checks++; if (f_busy !== 1'b1) begin errors++; $display("FAIL fast_busy_last: got %b want 1", f_busy); end
         end
         if (i == FRAME_F + 1) begin
            checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL fast_busy_fall: got %b want 0", f_busy); end
         end
      end
      checks++; if (wave_err != 0) begin errors++; $display("FAIL fast_wave: %0d bad cycles, first at %0d, want 0", wave_err, first_bad); end
      checks++; if (busy_cnt != FRAME_F) begin errors++; $display("FAIL fast_busy_len: got %0d want %0d", busy_cnt, FRAME_F); end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_single_byte();
      @(negedge clk);
      test_back_to_back();
      repeat (5) @(negedge clk);
      test_backpressure();
      repeat (5) @(negedge clk);
      test_reset_mid_frame();
      @(negedge clk);
      test_fast_rate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
